// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder arbiter.
// Optional feature macro used by the block: SERIAL_ADD_RR_EN (round-robin grant).
package serial_add_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Default operand/sum width
    localparam int WIDTH_DEFAULT = 16;

    // Largest legal operand width
    localparam int WIDTH_MAX = 32;

    // Bit counter width, sized for the largest legal operand width
    localparam int CNT_W = $clog2(WIDTH_MAX);

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: two operand shift registers, a one-bit full
// adder, a carry flop and a sum shift register. The controller drives the
// load and shift enables; load also clears the carry flop.
module serial_add_core
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             w_sum_bit;
    logic             w_carry_nxt;

    // One-bit full adder on the current LSBs and the fed-back carry
    always_comb begin
        w_sum_bit   = 1'b0;
        w_carry_nxt = 1'b0;
        w_sum_bit   = r_a[0] ^ r_b[0] ^ r_carry;
        w_carry_nxt = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    end

    // Parallel load, then shift LSB-first; sum bits enter at the MSB end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_sum   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sum   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
        end else if (i_shift) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_sum_bit, r_sum[WIDTH-1:1]};
            r_carry <= w_carry_nxt;
        end else begin
            r_a     <= r_a;
            r_b     <= r_b;
            r_sum   <= r_sum;
            r_carry <= r_carry;
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester arbiter in front of a bit-serial adder.
// One request is accepted in IDLE, loaded, added over WIDTH cycles, and the
// result is held in DONE until the consumer takes it.
// Optional feature macro: SERIAL_ADD_RR_EN -- round-robin grant on contention;
// when undefined, req0 has fixed priority and no pointer register exists.
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_id;
    logic               r_rsp_valid;
    logic               r_busy;
    logic               r_armed;
    logic               w_sel1;
    logic               w_grant;
    logic               w_load;
    logic               w_shift;
    logic               w_last_bit;

`ifdef SERIAL_ADD_RR_EN
    logic               r_last1;

    // Requester choice: on contention the one not granted last wins
    always_comb begin
        w_sel1 = 1'b0;
        if (req1_valid && (!req0_valid || !r_last1)) begin
            w_sel1 = 1'b1;
        end else begin
            w_sel1 = 1'b0;
        end
    end

    // Round-robin pointer; reset value lets req0 win the first contention
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last1 <= 1'b1;
        end else if (w_grant) begin
            r_last1 <= w_sel1;
        end else begin
            r_last1 <= r_last1;
        end
    end
`else
    // Requester choice: req0 has fixed priority over req1
    always_comb begin
        w_sel1 = 1'b0;
        if (req1_valid && !req0_valid) begin
            w_sel1 = 1'b1;
        end else begin
            w_sel1 = 1'b0;
        end
    end
`endif

    assign w_last_bit = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && (req0_valid || req1_valid)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (w_last_bit) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register plus registered valid/busy derived from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
            r_armed     <= 1'b1;
        end
    end

    // Bit counter: cleared on load, advanced once per shift cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_shift) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Capture the granted requester's operands and id at accept time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op_a <= {WIDTH{1'b0}};
            r_op_b <= {WIDTH{1'b0}};
            r_id   <= 1'b0;
        end else if (w_grant) begin
            r_op_a <= w_sel1 ? req1_a : req0_a;
            r_op_b <= w_sel1 ? req1_b : req0_b;
            r_id   <= w_sel1;
        end else begin
            r_op_a <= r_op_a;
            r_op_b <= r_op_b;
            r_id   <= r_id;
        end
    end

    serial_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_a     (r_op_a),
        .i_b     (r_op_b),
        .o_sum   (rsp_sum),
        .o_carry (rsp_carry)
    );

    // Ready is a same-cycle accept, so it is decoded from the grant
    assign req0_ready = w_grant & ~w_sel1;
    assign req1_ready = w_grant & w_sel1;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_id;
    assign busy       = r_busy;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter (WIDTH=16).
// Expected sequences follow SERIAL_ADD_RR_EN when it is defined.
module tb_serial_add_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
    logic [W-1:0] rsp_sum;

    typedef struct packed {
        logic         id;
        logic         carry;
        logic [W-1:0] sum;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_v = 1'b0;

    serial_add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_carry  (rsp_carry),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: push on accept, pop on handshake, latency on rise
    always @(negedge clk) begin
        logic [W:0] t;
        exp_t       e;
        if (reset) begin
            n_vec++;
            if (req0_ready && req1_ready) begin
                n_err++;
                $display("FAIL ready_excl: both ready high at cycle %0d, required at most one", cyc);
            end
            if (req0_valid && req0_ready) begin
                t = {1'b0, req0_a} + {1'b0, req0_b};
                sb.push_back({1'b0, t[W], t[W-1:0]});
                acc_cyc = cyc;
            end
            if (req1_valid && req1_ready) begin
                t = {1'b0, req1_a} + {1'b0, req1_b};
                sb.push_back({1'b1, t[W], t[W-1:0]});
                acc_cyc = cyc;
            end
            if (rsp_valid && !prev_v) begin
                n_vec++;
                if ((cyc - acc_cyc) !== (W + 2)) begin
                    n_err++;
                    $display("FAIL latency: got %0d cycles, required %0d", cyc - acc_cyc, W + 2);
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: response id=%0d sum=%h with nothing outstanding", rsp_id, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_carry, rsp_sum} !== e) begin
                        n_err++;
                        $display("FAIL sb_result: got id=%0d c=%0d sum=%h, required id=%0d c=%0d sum=%h",
                                 rsp_id, rsp_carry, rsp_sum, e.id, e.carry, e.sum);
                    end
                end
            end
        end
        prev_v = rsp_valid;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 16'h1111; req0_b = 16'h2222;
        req1_a = 16'h3333; req1_b = 16'h4444;
        rsp_ready  = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_carry, rsp_sum} !== {6'b000000, 16'h0000}) begin
            n_err++;
            $display("FAIL reset_outputs: v=%0d busy=%0d r0=%0d r1=%0d id=%0d c=%0d sum=%h, required all 0",
                     rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_carry, rsp_sum);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_req0_basic();
        logic found;
        req0_a = 16'h38A9; req0_b = 16'hBC99; req0_valid = 1'b1; rsp_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req0_ready) begin found = 1'b1; break; end
        end
        n_vec++;
        if (!found || req1_ready) begin
            n_err++;
            $display("FAIL req0_grant: ready0=%0d ready1=%0d, required 1/0", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0; req0_a = 16'h0000; req0_b = 16'h0000;
        @(negedge clk);
        n_vec++;
        if ({req0_ready, busy} !== 2'b01) begin
            n_err++;
            $display("FAIL req0_after_accept: ready0=%0d busy=%0d, required 0/1", req0_ready, busy);
        end
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin found = 1'b1; break; end
        end
        n_vec++;
        if (!found || {rsp_id, rsp_carry, rsp_sum} !== {2'b00, 16'hF542}) begin
            n_err++;
            $display("FAIL req0_result: v=%0d id=%0d c=%0d sum=%h, required 1/0/0/F542",
                     rsp_valid, rsp_id, rsp_carry, rsp_sum);
        end
        step();
    endtask

    task automatic test_req1_basic();
        logic found;
        req1_a = 16'hFFFF; req1_b = 16'h0001; req1_valid = 1'b1; rsp_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req1_ready) begin found = 1'b1; break; end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL req1_grant: ready1=%0d, required 1", req1_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            n_vec++;
            if (req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL req1_single_pulse: ready1=%0d after accept, required 0", req1_ready);
            end
        end
        req1_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin found = 1'b1; break; end
        end
        n_vec++;
        if (!found || {rsp_id, rsp_carry, rsp_sum} !== {2'b11, 16'h0000}) begin
            n_err++;
            $display("FAIL req1_result: v=%0d id=%0d c=%0d sum=%h, required 1/1/1/0000",
                     rsp_valid, rsp_id, rsp_carry, rsp_sum);
        end
        step();
    endtask

    task automatic test_hold();
        logic found;
        req0_a = 16'h0F0F; req0_b = 16'h00F1; req0_valid = 1'b1; rsp_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req0_ready) begin found = 1'b1; break; end
        end
        step();
        req0_valid = 1'b0;
        req1_a = 16'h0001; req1_b = 16'h0002; req1_valid = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid) begin found = 1'b1; break; end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL hold_reach_done: rsp_valid=%0d, required 1", rsp_valid);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge clk);
            n_vec++;
            if ({rsp_valid, busy, req0_ready, req1_ready, rsp_carry, rsp_sum} !== {5'b11000, 16'h1000}) begin
                n_err++;
                $display("FAIL hold_stable: v=%0d busy=%0d r0=%0d r1=%0d c=%0d sum=%h, required 1/1/0/0/0/1000",
                         rsp_valid, busy, req0_ready, req1_ready, rsp_carry, rsp_sum);
            end
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, req1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL hold_handshake: v=%0d ready1=%0d, required 1/0", rsp_valid, req1_ready);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_next_accept: ready1=%0d, required 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!busy) begin found = 1'b1; break; end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL hold_drain: busy=%0d, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_id [4];
        logic got_id [4];
        int   got_cyc [4];
        int   n;
`ifdef SERIAL_ADD_RR_EN
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        reset = 1'b0;
        req0_a = 16'h1234; req0_b = 16'h1111; req0_valid = 1'b1;
        req1_a = 16'h8000; req1_b = 16'h8001; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) step();
        sb.delete();
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 4 * (W + 3) + 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got_id[n]  = rsp_id;
                got_cyc[n] = cyc;
                n++;
                if (n == 4) break;
            end
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n_vec++;
        if (n != 4) begin
            n_err++;
            $display("FAIL b2b_count: got %0d responses, required 4", n);
        end
        for (int i = 0; i < n; i++) begin
            n_vec++;
            if (got_id[i] !== exp_id[i]) begin
                n_err++;
                $display("FAIL b2b_id[%0d]: got %0d, required %0d", i, got_id[i], exp_id[i]);
            end
            if (i > 0) begin
                n_vec++;
                if ((got_cyc[i] - got_cyc[i-1]) != (W + 3)) begin
                    n_err++;
                    $display("FAIL b2b_period[%0d]: got %0d cycles, required %0d",
                             i, got_cyc[i] - got_cyc[i-1], W + 3);
                end
            end
        end
        repeat (3) step();
    endtask

    task automatic test_reset_mid_shift();
        logic found;
        logic seen;
        req0_a = 16'h38A9; req0_b = 16'hBC99; req0_valid = 1'b1; rsp_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req0_ready) begin found = 1'b1; break; end
        end
        step();
        req0_valid = 1'b0;
        repeat (7) step();
        reset = 1'b0;
        #1;
        n_vec++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_carry, rsp_sum} !== {6'b000000, 16'h0000}) begin
            n_err++;
            $display("FAIL midshift_reset: v=%0d busy=%0d r0=%0d r1=%0d id=%0d c=%0d sum=%h, required all 0",
                     rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_carry, rsp_sum);
        end
        sb.delete();
        repeat (2) step();
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midshift_abandon: activity seen=%0d after reset, required 0", seen);
        end
    endtask

    initial begin
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 16'h0000; req0_b = 16'h0000; req1_a = 16'h0000; req1_b = 16'h0000;
        test_reset();
        test_req0_basic();
        test_req1_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid_shift();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
